// File: rtl/s_16bit_16_unfold.sv
// Receive-side unfold of the 16-to-8 XOR fold: rebuilds {fold^lo, lo} for channels a/b into a small output FIFO.
// Optional per-entry parity checking is enabled with `define UNFOLD_PARITY_EN.
//
// state   | meaning
// EMPTY   | occ == 0, out_valid low, a/b forced to zero
// PARTIAL | 0 < occ < DEPTH, push and pop both allowed
// FULL    | occ == DEPTH, in_ready low, input ignored
module s_16bit_16_unfold #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       aa,
  input  logic [7:0]       a_lo,
  input  logic [7:0]       bb,
  input  logic [7:0]       b_lo,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      a,
  output logic [15:0]      b,
  output logic [CNT_W-1:0] word_cnt
`ifdef UNFOLD_PARITY_EN
  ,
  input  logic             a_par,
  input  logic             b_par,
  output logic             par_err,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      occ_q, occ_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [15:0]      mem_a_q [DEPTH];
  logic [15:0]      mem_b_q [DEPTH];
  logic             push, pop;

  // Handshake comes only from registered state, so no input reaches an output combinationally.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    occ_d   = occ_q;
    state_d = state_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (occ_d == '0)
      state_d = EMPTY;
    else if (occ_d == OCC_FULL)
      state_d = FULL;
    else
      state_d = PARTIAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: contents are unreachable until rewritten.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q] <= {aa ^ a_lo, a_lo};
      mem_b_q[wr_ptr_q] <= {bb ^ b_lo, b_lo};
    end
  end

  assign a        = out_valid ? mem_a_q[rd_ptr_q] : 16'h0000;
  assign b        = out_valid ? mem_b_q[rd_ptr_q] : 16'h0000;
  assign word_cnt = word_cnt_q;

`ifdef UNFOLD_PARITY_EN
  logic             mem_pa_q [DEPTH];
  logic             mem_pb_q [DEPTH];
  logic [CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pa_q[wr_ptr_q] <= a_par;
      mem_pb_q[wr_ptr_q] <= b_par;
    end
  end

  assign par_err = out_valid &&
                   (((^a) != mem_pa_q[rd_ptr_q]) || ((^b) != mem_pb_q[rd_ptr_q]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_cnt_q <= '0;
    else if (pop && par_err)
      err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_s_16bit_16_unfold.sv
// Bench for s_16bit_16_unfold: queue-based model checked every cycle plus hand-computed literal checks.
module tb_s_16bit_16_unfold;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] aa = '0, a_lo = '0, bb = '0, b_lo = '0;
  logic in_ready, out_valid;
  logic [15:0] a, b;
  logic [CNT_W-1:0] word_cnt;
  logic a_par = 1'b0, b_par = 1'b0;
`ifdef UNFOLD_PARITY_EN
  logic par_err;
  logic [CNT_W-1:0] err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  s_16bit_16_unfold #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .aa(aa), .a_lo(a_lo), .bb(bb), .b_lo(b_lo),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .word_cnt(word_cnt)
`ifdef UNFOLD_PARITY_EN
    , .a_par(a_par), .b_par(b_par), .par_err(par_err), .err_cnt(err_cnt)
`endif
  );

  // Model entry: {a_par, b_par, a[15:0], b[15:0]}
  logic [33:0] q[$];
  logic [CNT_W-1:0] m_cnt = '0;
  logic [CNT_W-1:0] m_err = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic head_bad();
    logic [33:0] h;
    if (q.size() == 0) return 1'b0;
    h = q[0];
    return ((^h[31:16]) != h[33]) || ((^h[15:0]) != h[32]);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic do_push, do_pop;
    if (rst) begin
      q.delete();
      m_cnt = '0;
      m_err = '0;
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = (q.size() > 0) && out_ready;
      if (do_pop) begin
        if (head_bad()) m_err = m_err + 1'b1;
        void'(q.pop_front());
        m_cnt = m_cnt + 1'b1;
      end
      if (do_push)
        q.push_back({a_par, b_par, aa ^ a_lo, a_lo, bb ^ b_lo, b_lo});
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, (q.size() != DEPTH));
    chk("out_valid", out_valid, (q.size() != 0));
    chk("a", a, (q.size() != 0) ? q[0][31:16] : 16'h0);
    chk("b", b, (q.size() != 0) ? q[0][15:0] : 16'h0);
    chk("word_cnt", word_cnt, m_cnt);
`ifdef UNFOLD_PARITY_EN
    chk("par_err", par_err, head_bad());
    chk("err_cnt", err_cnt, m_err);
`endif
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] f_a, input logic [7:0] l_a,
                        input logic [7:0] f_b, input logic [7:0] l_b);
    aa = f_a; a_lo = l_a; bb = f_b; b_lo = l_b;
    a_par = ^{f_a ^ l_a, l_a};
    b_par = ^{f_b ^ l_b, l_b};
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;

    // Basic unfold
    set_in(8'hFF, 8'h0F, 8'h00, 8'h5A);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("basic_valid", out_valid, 1);
    chk("basic_a", a, 16'hF00F);
    chk("basic_b", b, 16'h5A5A);
    step();
    chk("basic_cnt", word_cnt, 1);

    // Backpressure
    out_ready = 1'b0;
    set_in(8'h12, 8'h34, 8'hAB, 8'hCD); in_valid = 1'b1;
    step();
    set_in(8'h01, 8'h02, 8'h03, 8'h04);
    step();
    chk("bp_in_ready", in_ready, 0);
    set_in(8'hC3, 8'h3C, 8'h99, 8'h66);
    step();
    step();
    chk("bp_hold_a", a, 16'h2634);
    chk("bp_hold_b", b, 16'h66CD);
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    chk("bp_cnt", word_cnt, 4);
    chk("bp_empty", out_valid, 0);

    // Concurrent push/pop at occ=1
    out_ready = 1'b0;
    set_in(8'h80, 8'h01, 8'h40, 8'h02); in_valid = 1'b1;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_in(8'(i * 17), 8'(8'hF0 - i), 8'(i * 3), 8'(8'h11 << (i % 4)));
      step();
      chk("cc_occ1", {in_ready, out_valid}, 2'b11);
    end
    in_valid = 1'b0;
    step();
    step();

    // Reset mid-operation with FIFO full
    out_ready = 1'b0;
    set_in(8'hAA, 8'h55, 8'h0F, 8'hF0); in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    chk("rst_pre_full", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_a", a, 16'h0);
    chk("rst_b", b, 16'h0);
    chk("rst_cnt", word_cnt, 0);
    step();
    rst = 1'b0;
    set_in(8'h5A, 8'hA5, 8'h01, 8'h10); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_a", a, 16'hFFA5);
    chk("post_rst_b", b, 16'h1110);
    out_ready = 1'b1;
    step();

    // Counter wrap (CNT_W=4): pair 1 was delivered above
    for (int k = 2; k <= 17; k++) begin
      set_in(8'(k), 8'(k * 5), 8'(~k), 8'(k + 7)); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      if (k == 15) chk("wrap_15", word_cnt, 15);
      if (k == 16) chk("wrap_16", word_cnt, 0);
      if (k == 17) chk("wrap_17", word_cnt, 1);
    end

`ifdef UNFOLD_PARITY_EN
    out_ready = 1'b0;
    set_in(8'hFF, 8'h0F, 8'h00, 8'h5A); a_par = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("par_err_bad", par_err, 1);
    out_ready = 1'b1;
    step();
    chk("err_cnt_1", err_cnt, 1);
    out_ready = 1'b0;
    set_in(8'hFF, 8'h0F, 8'h00, 8'h5A); a_par = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("par_err_good", par_err, 0);
    out_ready = 1'b1;
    step();
`endif

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
